// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EXE operand/store-data forwarding selects and load-use stall for the 5-stage pipeline.
// Define FWD_STATS_EN to add the stall and forward counters.
module fwd_hazard_ctrl #(
    parameter int REG_BITS = 5
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ID_Valid_IN,
    input  logic [REG_BITS-1:0] ID_RegA_IN,
    input  logic [REG_BITS-1:0] ID_RegB_IN,
    input  logic                ID_UsesA_IN,
    input  logic                ID_UsesB_IN,
    input  logic                ID_IsStore_IN,
    input  logic [REG_BITS-1:0] ID_WriteRegister_IN,
    input  logic                ID_RegWrite_IN,
    input  logic                ID_MemRead_IN,
    input  logic                Flush_IN,
    output logic                Stall_OUT,
    output logic [1:0]          RegA_Select,
    output logic [1:0]          RegB_Select,
    output logic [1:0]          MEM_Data_select
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]         Stall_Count_OUT,
    output logic [31:0]         Fwd_Count_OUT
`endif
);
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                regwrite;
        logic                memread;
    } shadow_t;

    shadow_t ex_q, ex_d, mem_q, mem_d;
    logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_m_q, sel_m_d;
    logic live_ex, live_mem, a_ex, a_mem, b_ex, b_mem, bubble;
    logic [1:0] a_raw, b_raw, m_raw;

    assign live_ex  = ex_q.valid & ex_q.regwrite & (ex_q.dest != '0);
    assign live_mem = mem_q.valid & mem_q.regwrite & (mem_q.dest != '0);
    assign a_ex  = live_ex & ID_UsesA_IN & (ID_RegA_IN == ex_q.dest);
    assign a_mem = live_mem & ID_UsesA_IN & (ID_RegA_IN == mem_q.dest);
    assign b_ex  = live_ex & ID_UsesB_IN & (ID_RegB_IN == ex_q.dest);
    assign b_mem = live_mem & ID_UsesB_IN & (ID_RegB_IN == mem_q.dest);

    // Store data is consumed in MEM, so a load one ahead can still feed it without a stall
    assign Stall_OUT = ID_Valid_IN & !Flush_IN & ex_q.memread & (a_ex | (b_ex & !ID_IsStore_IN));
    assign bubble    = !ID_Valid_IN | Stall_OUT | Flush_IN;

    always_comb begin
        a_raw   = (a_ex & !ex_q.memread) ? 2'd1 : a_mem ? 2'd2 : 2'd0;
        b_raw   = ID_IsStore_IN ? 2'd0 : (b_ex & !ex_q.memread) ? 2'd1 : b_mem ? 2'd2 : 2'd0;
        m_raw   = !ID_IsStore_IN ? 2'd0 : b_ex ? 2'd1 : b_mem ? 2'd2 : 2'd0;
        sel_a_d = bubble ? 2'd0 : a_raw;
        sel_b_d = bubble ? 2'd0 : b_raw;
        sel_m_d = bubble ? 2'd0 : m_raw;
        ex_d    = bubble ? '0 : '{valid: 1'b1, dest: ID_WriteRegister_IN,
                                  regwrite: ID_RegWrite_IN, memread: ID_MemRead_IN};
        mem_d   = ex_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            sel_m_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            sel_m_q <= sel_m_d;
        end
    end

    assign RegA_Select     = sel_a_q;
    assign RegB_Select     = sel_b_q;
    assign MEM_Data_select = sel_m_q;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(Stall_OUT);
        fwd_cnt_d   = fwd_cnt_q + 32'(|sel_a_d) + 32'(|sel_b_d) + 32'(|sel_m_d);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign Stall_Count_OUT = stall_cnt_q;
    assign Fwd_Count_OUT   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed instruction-stream vectors plus reset and counter sequences.
module tb_fwd_hazard_ctrl;
    logic       CLK = 0, RESET = 0;
    logic       v, ua, ub, st, rw, mr, fl;
    logic [4:0] ra, rb, wr;
    logic       stall;
    logic [1:0] sa, sb, sm;
`ifdef FWD_STATS_EN
    logic [31:0] scnt, fcnt;
`endif
    int n_chk = 0, n_fail = 0;

    fwd_hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET), .ID_Valid_IN(v), .ID_RegA_IN(ra), .ID_RegB_IN(rb),
        .ID_UsesA_IN(ua), .ID_UsesB_IN(ub), .ID_IsStore_IN(st), .ID_WriteRegister_IN(wr),
        .ID_RegWrite_IN(rw), .ID_MemRead_IN(mr), .Flush_IN(fl), .Stall_OUT(stall),
        .RegA_Select(sa), .RegB_Select(sb), .MEM_Data_select(sm)
`ifdef FWD_STATS_EN
        , .Stall_Count_OUT(scnt), .Fwd_Count_OUT(fcnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic v; logic [4:0] ra, rb; logic ua, ub, st; logic [4:0] wr; logic rw, mr, fl;
        logic es; logic [1:0] ea, eb, em;
    } vec_t;

    function automatic vec_t ins(int v_, ra_, rb_, ua_, ub_, st_, wr_, rw_, mr_, fl_, es_, ea_, eb_, em_);
        vec_t t;
        t = '{v: 1'(v_), ra: 5'(ra_), rb: 5'(rb_), ua: 1'(ua_), ub: 1'(ub_), st: 1'(st_),
              wr: 5'(wr_), rw: 1'(rw_), mr: 1'(mr_), fl: 1'(fl_),
              es: 1'(es_), ea: 2'(ea_), eb: 2'(eb_), em: 2'(em_)};
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        v = t.v; ra = t.ra; rb = t.rb; ua = t.ua; ub = t.ub; st = t.st;
        wr = t.wr; rw = t.rw; mr = t.mr; fl = t.fl;
    endtask

    task automatic step(input string nm, input vec_t t);
        @(negedge CLK);
        drive(t);
        #1 chk({nm, ".stall"}, int'(stall), int'(t.es));
        @(posedge CLK);
        #1;
        chk({nm, ".rega"}, int'(sa), int'(t.ea));
        chk({nm, ".regb"}, int'(sb), int'(t.eb));
        chk({nm, ".memdata"}, int'(sm), int'(t.em));
    endtask

    vec_t vecs[24];
    vec_t nop, lw8, add9;

    initial begin
        nop  = ins(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
        lw8  = ins(1,1,0,1,0,0,8,1,1,0, 0,0,0,0);
        add9 = ins(1,8,8,1,1,0,9,1,0,0, 0,0,0,0);
        vecs[0]  = ins(1,1,2,1,1,0,3,1,0,0,   0,0,0,0);
        vecs[1]  = ins(1,3,5,1,1,0,4,1,0,0,   0,1,0,0);
        vecs[2]  = nop;
        vecs[3]  = ins(1,1,2,1,1,0,3,1,0,0,   0,0,0,0);
        vecs[4]  = nop;
        vecs[5]  = ins(1,7,3,1,1,0,6,1,0,0,   0,0,2,0);
        vecs[6]  = ins(1,1,2,1,1,0,3,1,0,0,   0,0,0,0);
        vecs[7]  = ins(1,1,2,1,1,0,3,1,0,0,   0,0,0,0);
        vecs[8]  = ins(1,3,3,1,1,0,11,1,0,0,  0,1,1,0);
        vecs[9]  = lw8;
        vecs[10] = ins(1,8,8,1,1,0,9,1,0,0,   1,0,0,0);
        vecs[11] = ins(1,8,8,1,1,0,9,1,0,0,   0,2,2,0);
        vecs[12] = lw8;
        vecs[13] = ins(1,10,8,1,1,1,0,0,0,0,  0,0,0,1);
        vecs[14] = ins(1,10,8,1,1,1,0,0,0,0,  0,0,0,2);
        vecs[15] = ins(1,1,0,1,0,0,0,1,0,0,   0,0,0,0);
        vecs[16] = ins(1,0,0,1,1,0,12,1,0,0,  0,0,0,0);
        vecs[17] = lw8;
        vecs[18] = ins(1,8,8,1,1,0,9,1,0,1,   0,0,0,0);
        vecs[19] = ins(1,9,8,1,1,0,14,1,0,0,  0,0,2,0);
        vecs[20] = ins(1,14,14,0,0,0,0,0,0,0, 0,0,0,0);
        vecs[21] = lw8;
        vecs[22] = ins(1,8,9,1,1,1,0,0,0,0,   1,0,0,0);
        vecs[23] = ins(1,8,9,1,1,1,0,0,0,0,   0,2,0,0);

        drive(nop);
        @(posedge CLK);
        #1;
        chk("reset.stall", int'(stall), 0);
        chk("reset.rega", int'(sa), 0);
        chk("reset.regb", int'(sb), 0);
        chk("reset.memdata", int'(sm), 0);
        @(negedge CLK);
        RESET = 1;

        for (int i = 0; i < 24; i++) step($sformatf("vec%0d", i), vecs[i]);

        // Nonzero select registered, load-use pending, then async reset between edges
        step("pre_reset_add3", ins(1,1,2,1,1,0,3,1,0,0, 0,0,0,0));
        step("pre_reset_lw8", ins(1,3,0,1,0,0,8,1,1,0, 0,1,0,0));
        @(negedge CLK);
        drive(add9);
        #1 chk("hold.stall", int'(stall), 1);
        chk("hold.rega", int'(sa), 1);
        RESET = 0;
        #1;
        chk("async_reset.stall", int'(stall), 0);
        chk("async_reset.rega", int'(sa), 0);
        chk("async_reset.regb", int'(sb), 0);
        chk("async_reset.memdata", int'(sm), 0);
`ifdef FWD_STATS_EN
        chk("async_reset.stall_count", int'(scnt), 0);
        chk("async_reset.fwd_count", int'(fcnt), 0);
`endif
        @(negedge CLK);
        drive(nop);
        RESET = 1;

        step("cnt_lw8", lw8);
        step("cnt_add9_stall", ins(1,8,8,1,1,0,9,1,0,0, 1,0,0,0));
        step("cnt_add9", ins(1,8,8,1,1,0,9,1,0,0, 0,2,2,0));
`ifdef FWD_STATS_EN
        chk("stats.stall_count", int'(scnt), 1);
        chk("stats.fwd_count", int'(fcnt), 2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
